// File: rtl/ulpi_rx_packetizer.sv
// ULPI receive packetizer: decodes RX CMD status, frames USB packets with
// SOP/EOP/error flags, checks PID/CRC and buffers entries in a FWFT FIFO.
module ulpi_rx_packetizer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dir,
  input  logic       i_nxt,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_sop,
  output logic       o_eop,
  output logic       o_err,
  output logic [1:0] o_linestate,
  output logic [1:0] o_vbus,
  output logic       o_rx_active,
  output logic       o_host_disc,
  output logic       o_id,
  output logic       o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PID  = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ b[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t        state_r;
  logic          dir_q_r;
  logic [1:0]    rx_event_r;
  logic [7:0]    pid_r;
  logic [7:0]    hold_data_r;
  logic          hold_sop_r;
  logic          err_flag_r;
  logic [10:0]   body_cnt_r;
  logic [4:0]    crc5_r;
  logic [15:0]   crc16_r;
  logic [10:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          rx_cmd_s;
  logic          data_byte_s;
  logic          dir_fall_s;
  logic          eop_s;
  logic          rx_err_s;
  logic          guard_s;
  logic          class_bad_s;
  logic          pkt_bad_s;
  logic          push_s;
  logic [10:0]   push_entry_s;
  logic          wr_en_s;
  logic          pop_s;
  logic [CW-1:0] count_next_s;

  // Bus decode; the guard keeps one slot behind the held byte for a terminator.
  always_comb begin
    rx_cmd_s    = i_dir & dir_q_r & ~i_nxt;
    data_byte_s = i_dir & dir_q_r & i_nxt;
    dir_fall_s  = ~i_dir & dir_q_r;
    eop_s       = (state_r != ST_IDLE) &
                  ((rx_cmd_s & (i_data[5:4] == 2'b00)) | dir_fall_s);
    rx_err_s    = rx_cmd_s & (i_data[5:4] == 2'b11);
    guard_s     = (count_r > CW'(FIFO_DEPTH - 3));
  end

  // Packet verdict evaluated at end of packet.
  always_comb begin
    case (pid_r[1:0])
      2'b01:   class_bad_s = (body_cnt_r != 11'd2) | (crc5_r != 5'b01100);
      2'b11:   class_bad_s = (body_cnt_r < 11'd2) | (body_cnt_r > 11'd1026) |
                             (crc16_r != 16'h800D);
      2'b10:   class_bad_s = (body_cnt_r != 11'd0);
      default: class_bad_s = 1'b0;
    endcase
    pkt_bad_s = err_flag_r | class_bad_s | (pid_r[3:0] != ~pid_r[7:4]) |
                (dir_fall_s & (rx_event_r != 2'b00));
  end

  // Select what the holding register hands to the FIFO this cycle.
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = 11'h000;
    if ((state_r == ST_PID) || (state_r == ST_BODY)) begin
      if (eop_s) begin
        push_s       = 1'b1;
        push_entry_s = {hold_sop_r, 1'b1, pkt_bad_s, hold_data_r};
      end else if (data_byte_s) begin
        push_s = 1'b1;
        if (guard_s) push_entry_s = {1'b0, 1'b1, 1'b1, 8'h00};
        else         push_entry_s = {hold_sop_r, 1'b0, 1'b0, hold_data_r};
      end else begin
        push_s       = 1'b0;
        push_entry_s = 11'h000;
      end
    end else begin
      push_s       = 1'b0;
      push_entry_s = 11'h000;
    end
  end

  // FIFO handshake and occupancy arithmetic.
  always_comb begin
    pop_s        = o_valid & i_ready;
    wr_en_s      = push_s & (count_r != CW'(FIFO_DEPTH));
    count_next_s = count_r + CW'(wr_en_s) - CW'(pop_s);
  end

  assign {o_sop, o_eop, o_err, o_data} = o_valid ? mem_r[rd_ptr_r] : 11'h000;

  // FIFO storage; contents are qualified by o_valid so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= push_entry_s;
  end

  // FIFO pointers, occupancy and head-valid flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      o_valid  <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      o_valid <= (count_next_s != {CW{1'b0}});
    end
  end

  // RX CMD status capture and DIR history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q_r     <= 1'b0;
      rx_event_r  <= 2'b00;
      o_linestate <= 2'b00;
      o_vbus      <= 2'b00;
      o_rx_active <= 1'b0;
      o_host_disc <= 1'b0;
      o_id        <= 1'b0;
    end else begin
      dir_q_r <= i_dir;
      if (rx_cmd_s) begin
        rx_event_r  <= i_data[5:4];
        o_linestate <= i_data[1:0];
        o_vbus      <= i_data[3:2];
        o_rx_active <= i_data[4];
        o_host_disc <= (i_data[5:4] == 2'b10);
        o_id        <= i_data[6];
      end
    end
  end

  // Packet framing FSM with running CRC and body length.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      pid_r       <= 8'h00;
      hold_data_r <= 8'h00;
      hold_sop_r  <= 1'b0;
      err_flag_r  <= 1'b0;
      body_cnt_r  <= 11'd0;
      crc5_r      <= 5'h1F;
      crc16_r     <= 16'hFFFF;
      o_overflow  <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (data_byte_s) begin
            state_r     <= ST_PID;
            pid_r       <= i_data;
            hold_data_r <= i_data;
            hold_sop_r  <= 1'b1;
            err_flag_r  <= 1'b0;
            body_cnt_r  <= 11'd0;
            crc5_r      <= 5'h1F;
            crc16_r     <= 16'hFFFF;
          end
        end
        ST_PID, ST_BODY: begin
          if (eop_s) begin
            state_r <= ST_IDLE;
          end else if (data_byte_s && guard_s) begin
            state_r    <= ST_DROP;
            o_overflow <= 1'b1;
          end else begin
            state_r <= ST_BODY;
            if (rx_err_s) err_flag_r <= 1'b1;
            if (data_byte_s) begin
              hold_data_r <= i_data;
              hold_sop_r  <= 1'b0;
              if (body_cnt_r != 11'h7FF) body_cnt_r <= body_cnt_r + 11'd1;
              crc5_r  <= crc5_byte(crc5_r, i_data);
              crc16_r <= crc16_byte(crc16_r, i_data);
            end
          end
        end
        ST_DROP: begin
          if (eop_s) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
